// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
//   Shares one SPI transmitter between N_REQ requesters. A round-robin pick
//   is made from IDLE; the winner's 12-bit payload is latched onto spi_din and
//   spi_newd is raised until the transmitter drops cs. The frame completes on
//   the following cs rise. A watchdog aborts a frame that stalls for TIMEOUT
//   cycles waiting for either cs edge.
//
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester level request
//   req_data  : per-requester payload, slice k = [12k+11:12k]
//   gnt       : one-cycle pulse, payload of requester k captured
//   done      : one-cycle pulse, requester k's frame completed
//   err       : one-cycle pulse, requester k's frame aborted by timeout
//   spi_newd  : new-frame request to the SPI transmitter
//   spi_din   : payload to the SPI transmitter
//   spi_cs    : transmitter chip select (active-low, asynchronous here)
//   busy      : high whenever the arbiter is not idle
module spi_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*12-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [N_REQ-1:0]    err,
    output logic               spi_newd,
    output logic [11:0]        spi_din,
    input  logic               spi_cs,
    output logic               busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, DONE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   last, last_n;
    logic [IW-1:0]   cur, cur_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_REQ-1:0] gnt_n, done_n, err_n;
    logic            newd_n;
    logic [11:0]     din_n;

    logic            cs_s1, cs_s2, cs_q;
    logic            cs_fall, cs_rise, tmo;
    logic            pick_valid;
    logic [IW-1:0]   pick;

    // cs_s1/cs_s2 form the synchronizer; cs_q holds the previous synchronized
    // value for edge detection. All reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_s1 <= 1'b1;
            cs_s2 <= 1'b1;
            cs_q  <= 1'b1;
        end else begin
            cs_s1 <= spi_cs;
            cs_s2 <= cs_s1;
            cs_q  <= cs_s2;
        end
    end

    assign cs_fall = cs_q & ~cs_s2;
    assign cs_rise = ~cs_q & cs_s2;
    assign tmo     = (cnt == CW'(TIMEOUT - 1));
    assign busy    = (state != IDLE);

    // Round-robin search starting one past the last served requester.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!pick_valid && req[IW'((32'(last) + i) % N_REQ)]) begin
                pick       = IW'((32'(last) + i) % N_REQ);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        cur_n   = cur;
        cnt_n   = cnt;
        gnt_n   = '0;
        done_n  = '0;
        err_n   = '0;
        newd_n  = spi_newd;
        din_n   = spi_din;
        case (state)
            IDLE: begin
                newd_n = 1'b0;
                if (pick_valid) begin
                    cur_n   = pick;
                    din_n   = req_data[32'(pick)*12 +: 12];
                    gnt_n   = N_REQ'(1) << pick;
                    newd_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // Edge is tested before the terminal count so it wins a tie.
                if (cs_fall) begin
                    newd_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = WAIT_END;
                end else if (tmo) begin
                    err_n   = N_REQ'(1) << cur;
                    newd_n  = 1'b0;
                    last_n  = cur;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_END: begin
                if (cs_rise) begin
                    done_n  = N_REQ'(1) << cur;
                    state_n = DONE;
                end else if (tmo) begin
                    err_n   = N_REQ'(1) << cur;
                    last_n  = cur;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                last_n  = cur;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Pulses are registered on the transition, so gnt is seen in the first
    // ISSUE cycle, done during DONE and err in the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= IW'(N_REQ - 1);
            cur      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= '0;
            spi_newd <= 1'b0;
            spi_din  <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            cur      <= cur_n;
            cnt      <= cnt_n;
            gnt      <= gnt_n;
            done     <= done_n;
            err      <= err_n;
            spi_newd <= newd_n;
            spi_din  <= din_n;
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter
//   Directed and randomized frames against spi_tx_arbiter. The bench plays the
//   SPI transmitter (drives spi_cs) and predicts grant order, payload, and the
//   done/err outcome from the round-robin and watchdog rules.
module tb_spi_tx_arbiter;

    localparam int N = 4;
    localparam int T = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*12-1:0] req_data;
    logic [N-1:0]    gnt, done, err;
    logic            spi_newd;
    logic [11:0]     spi_din;
    logic            spi_cs;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int lg;

    spi_tx_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .spi_newd (spi_newd),
        .spi_din  (spi_din),
        .spi_cs   (spi_cs),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    // One frame. f: negedges after gnt before cs falls (<0: never falls).
    // r: negedges from cs fall to cs rise. next_req is applied once the
    // outcome pulse is seen, which is what the following arbitration uses.
    task automatic frame(input int f, input int r, input logic [N-1:0] next_req, input bit scramble);
        int k, n;
        logic [11:0] d;
        logic [63:0] rnd;
        k = pick(req, lg);
        d = req_data[12*k +: 12];
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == '0 && n < 40);
        check("gnt", gnt, N'(1) << k);
        check("gnt_din", spi_din, d);
        check("gnt_newd", spi_newd, 1);
        check("gnt_excl", {done, err}, 0);
        rnd = {$urandom(), $urandom()};
        req_data = rnd[N*12-1:0];
        if (scramble) req = N'($urandom());
        if (f < 0) begin
            n = 0;
            do begin @(negedge clk); n++; end while (err == '0 && done == '0 && n < T + 10);
            check("tmo_lat", n, T);
            check("tmo_err", err, N'(1) << k);
            check("tmo_done", done, 0);
            check("tmo_newd", spi_newd, 0);
            check("tmo_busy", busy, 0);
            lg  = k;
            req = next_req;
        end else begin
            repeat (f) @(negedge clk);
            check("pre_fall_newd", spi_newd, 1);
            spi_cs = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (spi_newd && n < 20);
            check("fall_lat", n, 3);
            check("wait_din", spi_din, d);
            repeat (r - 3) @(negedge clk);
            spi_cs = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (done == '0 && err == '0 && n < T + 10);
            lg = k;
            if (r <= T) begin
                check("done_lat", n, 3);
                check("done", done, N'(1) << k);
                check("done_err", err, 0);
                check("done_din", spi_din, d);
                check("done_busy", busy, 1);
                req = next_req;
                @(negedge clk);
                check("done_pulse", done, 0);
                check("idle_busy", busy, 0);
            end else begin
                check("wend_tmo_lat", n, T + 3 - r);
                check("wend_err", err, N'(1) << k);
                check("wend_done", done, 0);
                check("wend_busy", busy, 0);
                req = next_req;
            end
        end
    endtask

    initial begin
        int k, n;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        spi_cs   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_newd", spi_newd, 0);
        check("rst_din", spi_din, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        lg  = N - 1;

        // Single requester, long frame.
        req_data[11:0] = 12'hA5C;
        req = 4'b0001;
        frame(30, 50, 4'b0100, 1'b0);

        // cs never falls; next grant must go to 3.
        frame(-1, 0, 4'b1111, 1'b0);
        frame(5, 20, 4'b0010, 1'b0);

        // Reset in the middle of WAIT_END.
        k = pick(req, lg);
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == '0 && n < 40);
        check("mid_gnt", gnt, N'(1) << k);
        repeat (2) @(negedge clk);
        spi_cs = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (spi_newd && n < 20);
        check("mid_newd", spi_newd, 0);
        req = 4'b1111;
        repeat (4) @(negedge clk);
        rst    = 1'b1;
        spi_cs = 1'b1;
        @(negedge clk);
        check("mrst_gnt", gnt, 0);
        check("mrst_done_err", {done, err}, 0);
        check("mrst_newd", spi_newd, 0);
        check("mrst_din", spi_din, 0);
        check("mrst_busy", busy, 0);
        rst = 1'b0;
        lg  = N - 1;

        // All requesting: strict rotation starting at 0.
        for (int i = 0; i < 8; i++) begin
            frame(int'($urandom_range(0, 20)), int'($urandom_range(3, 30)),
                  (i == 7) ? 4'b0010 : 4'b1111, 1'b0);
        end

        // Payload for 1 is overwritten right after its grant.
        req_data[23:12] = 12'h123;
        frame(10, 40, 4'b1111, 1'b1);

        // Boundaries of the watchdog.
        frame(T - 3, 10, 4'b1111, 1'b0);
        frame(4, T, 4'b1111, 1'b0);
        frame(4, T + 1, 4'b1111, 1'b0);

        for (int i = 0; i < 20; i++) begin
            frame(int'($urandom_range(0, 40)), int'($urandom_range(3, 50)),
                  N'($urandom_range(1, 15)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
